// File: rtl/joy_trackball_pkg.sv
// Shared types and helpers for the joystick-to-trackball emulator.
// Holds axis state/direction encodings, the quadrature Gray table and the period update rule.
package joy_trackball_pkg;

  typedef enum logic {
    AX_IDLE = 1'b0,
    AX_RUN  = 1'b1
  } ax_state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_POS  = 2'd1,
    DIR_NEG  = 2'd2
  } dir_e;

  // Phase index -> {A,B}; walking up the index is the +1 direction.
  localparam logic [3:0][1:0] GRAY_AB = {2'b10, 2'b11, 2'b01, 2'b00};

  function automatic dir_e dir_req(input logic pos, input logic neg);
    dir_e res;
    res = DIR_NONE;
    if (pos && !neg) begin
      res = DIR_POS;
    end else if (neg && !pos) begin
      res = DIR_NEG;
    end
    return res;
  endfunction

  // Subtract in 9 bits so a large step saturates at the floor instead of wrapping.
  function automatic logic [7:0] next_period(input logic [7:0] period,
                                             input logic [7:0] accel,
                                             input logic [7:0] min_p);
    logic [8:0] diff;
    logic [7:0] res;
    diff = {1'b0, period} - {1'b0, accel};
    res  = diff[7:0];
    if (diff[8] || (diff[7:0] < min_p)) begin
      res = min_p;
    end
    return res;
  endfunction

endpackage

// File: rtl/joy_trackball_axis.sv
// One trackball axis: IDLE/RUN FSM with accelerating step period, quadrature phase and step count.
// Steps are decided on tick cycles only and appear on the registered outputs one clock later.
module joy_trackball_axis
  import joy_trackball_pkg::*;
#(
  parameter logic [7:0] MAX_PERIOD = 8'd16,
  parameter logic [7:0] MIN_PERIOD = 8'd2,
  parameter logic [7:0] ACCEL_STEP = 8'd1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       tick_i,
  input  logic       pos_i,
  input  logic       neg_i,
  output logic       a_o,
  output logic       b_o,
  output logic [7:0] cnt_o
);

  localparam logic [7:0] MAX_CD = MAX_PERIOD - 8'd1;

  ax_state_e  state_q, state_d;
  dir_e       dir_q, dir_d;
  logic [7:0] period_q, period_d;
  logic [7:0] cd_q, cd_d;
  logic [1:0] phase_q, phase_d;
  logic [1:0] ab_q, ab_d;
  logic [7:0] cnt_q, cnt_d;

  dir_e       req;
  dir_e       step_dir;
  logic [7:0] newp;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= AX_IDLE;
      dir_q    <= DIR_NONE;
      period_q <= MAX_PERIOD;
      cd_q     <= 8'd0;
      phase_q  <= 2'd0;
      ab_q     <= 2'b00;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      period_q <= period_d;
      cd_q     <= cd_d;
      phase_q  <= phase_d;
      ab_q     <= ab_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    period_d = period_q;
    cd_d     = cd_q;
    step_dir = DIR_NONE;
    req      = dir_req(pos_i, neg_i);
    newp     = next_period(period_q, ACCEL_STEP, MIN_PERIOD);

    if (tick_i) begin
      case (state_q)
        AX_IDLE: begin
          if (req != DIR_NONE) begin
            step_dir = req;
            dir_d    = req;
            period_d = MAX_PERIOD;
            cd_d     = MAX_CD;
            state_d  = AX_RUN;
          end
        end
        AX_RUN: begin
          if (req == DIR_NONE) begin
            state_d  = AX_IDLE;
            period_d = MAX_PERIOD;
          end else if (req != dir_q) begin
            // Reversal restarts motion from the slowest speed.
            step_dir = req;
            dir_d    = req;
            period_d = MAX_PERIOD;
            cd_d     = MAX_CD;
          end else if (cd_q != 8'd0) begin
            cd_d = cd_q - 8'd1;
          end else begin
            step_dir = dir_q;
            period_d = newp;
            cd_d     = newp - 8'd1;
          end
        end
        default: begin
          state_d = AX_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    case (step_dir)
      DIR_POS: begin
        phase_d = phase_q + 2'd1;
        cnt_d   = cnt_q + 8'd1;
      end
      DIR_NEG: begin
        phase_d = phase_q - 2'd1;
        cnt_d   = cnt_q - 8'd1;
      end
      default: begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
      end
    endcase
    ab_d = GRAY_AB[phase_d];
  end

  assign a_o   = ab_q[1];
  assign b_o   = ab_q[0];
  assign cnt_o = cnt_q;

endmodule

// File: rtl/joy_trackball.sv
// Joystick directions to Crystal Castles trackball quadrature, with per-axis acceleration.
// Joystick edges reach the axis FSMs after a 2-flop sync; steps show one clock after a tick.
module joy_trackball
  import joy_trackball_pkg::*;
#(
  parameter int unsigned PRESCALE   = 1024,
  parameter logic [7:0]  MAX_PERIOD = 8'd16,
  parameter logic [7:0]  MIN_PERIOD = 8'd2,
  parameter logic [7:0]  ACCEL_STEP = 8'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       joy_right,
  input  logic       joy_left,
  input  logic       joy_down,
  input  logic       joy_up,
  input  logic       flip,
  output logic       trak_h_a,
  output logic       trak_h_b,
  output logic       trak_v_a,
  output logic       trak_v_b,
  output logic [7:0] cnt_h,
  output logic [7:0] cnt_v
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  // Bit order {up, down, left, right}.
  logic [3:0]    meta_q, sync_q;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic          h_pos, h_neg, v_pos, v_neg;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q  <= 4'b0000;
      sync_q  <= 4'b0000;
      presc_q <= '0;
    end else begin
      meta_q  <= {joy_up, joy_down, joy_left, joy_right};
      sync_q  <= meta_q;
      presc_q <= presc_d;
    end
  end

  always_comb begin
    tick    = (presc_q == PRE_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  // Cocktail flip mirrors both axes.
  always_comb begin
    h_pos = flip ? sync_q[1] : sync_q[0];
    h_neg = flip ? sync_q[0] : sync_q[1];
    v_pos = flip ? sync_q[3] : sync_q[2];
    v_neg = flip ? sync_q[2] : sync_q[3];
  end

  joy_trackball_axis #(
    .MAX_PERIOD (MAX_PERIOD),
    .MIN_PERIOD (MIN_PERIOD),
    .ACCEL_STEP (ACCEL_STEP)
  ) u_axis_h (
    .clk_i   (clk),
    .reset_i (reset),
    .tick_i  (tick),
    .pos_i   (h_pos),
    .neg_i   (h_neg),
    .a_o     (trak_h_a),
    .b_o     (trak_h_b),
    .cnt_o   (cnt_h)
  );

  joy_trackball_axis #(
    .MAX_PERIOD (MAX_PERIOD),
    .MIN_PERIOD (MIN_PERIOD),
    .ACCEL_STEP (ACCEL_STEP)
  ) u_axis_v (
    .clk_i   (clk),
    .reset_i (reset),
    .tick_i  (tick),
    .pos_i   (v_pos),
    .neg_i   (v_neg),
    .a_o     (trak_v_a),
    .b_o     (trak_v_b),
    .cnt_o   (cnt_v)
  );

endmodule
